// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, the default
// bubble word, instruction size and the word-alignment mask.
package fetch_pkg;

  localparam logic [0:0]  BOOT             = 1'b0;
  localparam logic [0:0]  RUN              = 1'b1;

  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Bus bundle between the fetch PC unit and its neighbours (instruction
// memory, hazard/branch logic in later stages, decode).
//   start_addr       boot PC from instruction memory
//   mem_instruction  word returned for read_address (combinational read)
//   read_address     byte address to instruction memory (equals pc)
//   stall            hold PC and IF/ID
//   redirect_valid   branch/jump taken this cycle
//   redirect_target  redirect byte address (low two bits ignored)
//   ifid_instruction registered instruction to decode
//   ifid_pc_plus4    registered PC+4 of that instruction
//   ifid_valid       1 = real instruction, 0 = bubble
// master: environment side; slave: fetch_pc_unit side.
interface fetch_pc_unit_if;

  logic [31:0] start_addr;
  logic [31:0] mem_instruction;
  logic [31:0] read_address;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;

  modport master (
    output start_addr, mem_instruction, stall, redirect_valid, redirect_target,
    input  read_address, ifid_instruction, ifid_pc_plus4, ifid_valid
  );

  modport slave (
    input  start_addr, mem_instruction, stall, redirect_valid, redirect_target,
    output read_address, ifid_instruction, ifid_pc_plus4, ifid_valid
  );

endinterface

// File: rtl/fetch_pc_unit_ifid_reg.sv
// IF/ID pipeline register. Pure storage: on load it captures either the
// data word or a bubble (NOP_WORD, valid=0); pc_plus4 is captured either way.
//   clock, reset      pipeline clock, synchronous active-high reset
//   load              update the register this cycle
//   bubble            replace the instruction with NOP_WORD and clear valid
//   data_instruction  instruction word to capture
//   data_pc_plus4     PC+4 to capture
//   ifid_*            registered outputs
module ifid_reg #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic [31:0] data_instruction,
  input  logic [31:0] data_pc_plus4,
  output logic [31:0] ifid_instruction,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
);

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q,   pc4_d;
  logic        valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (load) begin
      instr_d = bubble ? NOP_WORD : data_instruction;
      pc4_d   = data_pc_plus4;
      valid_d = ~bubble;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      instr_q <= NOP_WORD;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign ifid_instruction = instr_q;
  assign ifid_pc_plus4    = pc4_q;
  assign ifid_valid       = valid_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter with a one-entry pending-redirect buffer,
// feeding the IF/ID register.
//   clock, reset  pipeline clock, synchronous active-high reset
//   bus           fetch_pc_unit_if.slave (memory, stall/redirect, IF/ID outs)
// Build option: BRANCH_DELAY_SLOT_EN -- when defined the word fetched in a
// redirect/pending-apply cycle is kept as the delay slot; otherwise it is
// squashed to a bubble.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  fetch_pc_unit_if.slave    bus
);

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pending_valid_q, pending_valid_d;
  logic [31:0] pending_target_q, pending_target_d;

  logic        ifid_load;
  logic        ifid_bubble;
  logic        wrong_path;
  logic [31:0] pc_plus4;
  logic [31:0] ifid_instruction;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;

  assign pc_plus4 = pc_q + INSTR_BYTES;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pending_valid_d  = pending_valid_q;
    pending_target_d = pending_target_q;
    ifid_load        = 1'b0;
    ifid_bubble      = 1'b0;
    wrong_path       = 1'b0;

    if (state_q == BOOT) begin
      pc_d        = bus.start_addr;
      state_d     = RUN;
      ifid_load   = 1'b1;
      ifid_bubble = 1'b1;
    end else if (bus.stall) begin
      // Redirects arriving while stalled are parked; the newest wins.
      if (bus.redirect_valid) begin
        pending_valid_d  = 1'b1;
        pending_target_d = bus.redirect_target & ALIGN_MASK;
      end
    end else begin
      ifid_load = 1'b1;
      if (bus.redirect_valid) begin
        pc_d            = bus.redirect_target & ALIGN_MASK;
        pending_valid_d = 1'b0;
        wrong_path      = 1'b1;
      end else if (pending_valid_q) begin
        pc_d            = pending_target_q;
        pending_valid_d = 1'b0;
        wrong_path      = 1'b1;
      end else begin
        pc_d = pc_plus4;
      end
`ifdef BRANCH_DELAY_SLOT_EN
      ifid_bubble = 1'b0;
`else
      ifid_bubble = wrong_path;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= BOOT;
      pc_q             <= RESET_PC;
      pending_valid_q  <= 1'b0;
      pending_target_q <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      pending_valid_q  <= pending_valid_d;
      pending_target_q <= pending_target_d;
    end
  end

  ifid_reg #(.NOP_WORD(NOP_WORD)) u_ifid_reg (
    .clock            (clock),
    .reset            (reset),
    .load             (ifid_load),
    .bubble           (ifid_bubble),
    .data_instruction (bus.mem_instruction),
    .data_pc_plus4    (pc_plus4),
    .ifid_instruction (ifid_instruction),
    .ifid_pc_plus4    (ifid_pc_plus4),
    .ifid_valid       (ifid_valid)
  );

  assign bus.read_address     = pc_q;
  assign bus.ifid_instruction = ifid_instruction;
  assign bus.ifid_pc_plus4    = ifid_pc_plus4;
  assign bus.ifid_valid       = ifid_valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;
`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic clock;
  logic reset;
  fetch_pc_unit_if ifc ();

  fetch_pc_unit #(.RESET_PC(RESET_PC), .NOP_WORD(NOP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0040_0000: mem_f = 32'h2008_0005;
      32'h0040_0010: mem_f = 32'h1234_5678;
      default:       mem_f = a ^ 32'hA5A5_5A5A;
    endcase
  endfunction

  assign ifc.mem_instruction = mem_f(ifc.read_address);

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural view of the fetch stage.
  bit          m_boot = 1'b1;
  logic [31:0] m_pc   = RESET_PC;
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_tgt = '0;
  logic [31:0] e_instr = NOP;
  logic [31:0] e_pc4   = '0;
  bit          e_valid = 1'b0;
  bit          e_pc4_known = 1'b1;
  bit          chk_en = 1'b0;
  bit          saw_200 = 1'b0;

  always @(posedge clock) begin
    if (reset) begin
      m_boot = 1'b1; m_pc = RESET_PC; m_pend = 1'b0; m_pend_tgt = '0;
      e_instr = NOP; e_pc4 = '0; e_valid = 1'b0; e_pc4_known = 1'b1;
    end else if (m_boot) begin
      m_boot = 1'b0;
      m_pc = ifc.start_addr;
      e_instr = NOP; e_valid = 1'b0; e_pc4_known = 1'b0;
    end else if (ifc.stall) begin
      if (ifc.redirect_valid) begin
        m_pend = 1'b1;
        m_pend_tgt = {ifc.redirect_target[31:2], 2'b00};
      end
    end else begin
      bit squash;
      squash = (ifc.redirect_valid || m_pend) && !DS;
      e_instr = squash ? NOP : mem_f(m_pc);
      e_valid = !squash;
      e_pc4 = m_pc + 32'd4;
      e_pc4_known = 1'b1;
      if (ifc.redirect_valid) begin
        m_pc = {ifc.redirect_target[31:2], 2'b00};
        m_pend = 1'b0;
      end else if (m_pend) begin
        m_pc = m_pend_tgt;
        m_pend = 1'b0;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_read_address", ifc.read_address, m_pc);
      check("model_ifid_valid", {31'd0, ifc.ifid_valid}, {31'd0, e_valid});
      check("model_ifid_instruction", ifc.ifid_instruction, e_instr);
      if (e_pc4_known) check("model_ifid_pc_plus4", ifc.ifid_pc_plus4, e_pc4);
      if (ifc.read_address == 32'h0040_0200) saw_200 = 1'b1;
    end
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    ifc.start_addr = 32'h0040_0000;
    ifc.stall = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_target = '0;

    // Boot
    cyc();
    chk_en = 1'b1;
    cyc();
    check("boot_reset_pc", ifc.read_address, 32'h0000_0000);
    check("boot_reset_valid", {31'd0, ifc.ifid_valid}, 32'd0);
    reset = 1'b0;
    ifc.stall = 1'b1;                     // ignored in BOOT
    ifc.redirect_valid = 1'b1;
    ifc.redirect_target = 32'h0000_0800;
    cyc();
    ifc.stall = 1'b0;
    ifc.redirect_valid = 1'b0;
    check("boot_start_addr", ifc.read_address, 32'h0040_0000);
    check("boot_bubble", {31'd0, ifc.ifid_valid}, 32'd0);
    cyc();
    check("first_next_pc", ifc.read_address, 32'h0040_0004);
    check("first_instr", ifc.ifid_instruction, 32'h2008_0005);
    check("first_pc4", ifc.ifid_pc_plus4, 32'h0040_0004);
    check("first_valid", {31'd0, ifc.ifid_valid}, 32'd1);
    cyc();
    check("pre_stall_pc", ifc.read_address, 32'h0040_0008);

    // Stall for exactly 3 cycles
    ifc.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_pc_hold", ifc.read_address, 32'h0040_0008);
      check("stall_pc4_hold", ifc.ifid_pc_plus4, 32'h0040_0008);
    end
    ifc.stall = 1'b0;
    cyc();
    check("stall_resume", ifc.read_address, 32'h0040_000C);
    check("stall_resume_pc4", ifc.ifid_pc_plus4, 32'h0040_000C);
    cyc();
    check("pre_redirect_pc", ifc.read_address, 32'h0040_0010);

    // Redirect with unaligned target
    ifc.redirect_valid = 1'b1;
    ifc.redirect_target = 32'h0040_0103;
    cyc();
    ifc.redirect_valid = 1'b0;
    check("redirect_pc", ifc.read_address, 32'h0040_0100);
    check("redirect_slot_valid", {31'd0, ifc.ifid_valid}, {31'd0, DS});
    check("redirect_slot_instr", ifc.ifid_instruction, DS ? 32'h1234_5678 : 32'h0000_0000);
    check("redirect_slot_pc4", ifc.ifid_pc_plus4, 32'h0040_0014);
    cyc();
    check("post_redirect_pc", ifc.read_address, 32'h0040_0104);

    // Two redirects while stalled; the newer one wins
    ifc.stall = 1'b1;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_target = 32'h0040_0200;
    cyc();
    check("stalled_redir1_hold", ifc.read_address, 32'h0040_0104);
    ifc.redirect_target = 32'h0040_0300;
    cyc();
    ifc.redirect_valid = 1'b0;
    cyc();
    check("stalled_redir_hold", ifc.read_address, 32'h0040_0104);
    ifc.stall = 1'b0;
    cyc();
    check("pending_apply_pc", ifc.read_address, 32'h0040_0300);
    check("pending_slot_valid", {31'd0, ifc.ifid_valid}, {31'd0, DS});
    cyc();
    check("pending_cleared_pc", ifc.read_address, 32'h0040_0304);
    check("pending_next_valid", {31'd0, ifc.ifid_valid}, 32'd1);
    check("first_target_never_fetched", {31'd0, saw_200}, 32'd0);

    // Wrap at top of address space
    ifc.redirect_valid = 1'b1;
    ifc.redirect_target = 32'hFFFF_FFFC;
    cyc();
    ifc.redirect_valid = 1'b0;
    check("wrap_pre_pc", ifc.read_address, 32'hFFFF_FFFC);
    cyc();
    check("wrap_pc", ifc.read_address, 32'h0000_0000);
    check("wrap_pc4", ifc.ifid_pc_plus4, 32'h0000_0000);
    check("wrap_instr", ifc.ifid_instruction, 32'h5A5A_A5A6);
    check("wrap_valid", {31'd0, ifc.ifid_valid}, 32'd1);

    // Reset during a stall with a redirect pending
    ifc.stall = 1'b1;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_target = 32'h0000_0500;
    cyc();
    ifc.redirect_valid = 1'b0;
    reset = 1'b1;
    cyc();
    check("midreset_pc", ifc.read_address, RESET_PC);
    check("midreset_valid", {31'd0, ifc.ifid_valid}, 32'd0);
    check("midreset_pc4", ifc.ifid_pc_plus4, 32'h0000_0000);
    check("midreset_instr", ifc.ifid_instruction, NOP);
    reset = 1'b0;
    ifc.start_addr = 32'h0000_1000;
    cyc();
    check("reboot_pc", ifc.read_address, 32'h0000_1000);
    ifc.stall = 1'b0;
    cyc();
    check("reboot_no_pending", ifc.read_address, 32'h0000_1004);
    for (int i = 0; i < 4; i++) cyc();
    check("run_after_reboot", ifc.read_address, 32'h0000_1014);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
